// File: rtl/pipe_hazard_ctrl_if.sv
// Control bundle between the pipeline hazard sequencer and the 5-stage datapath.
// The datapath side is the master; the sequencer is the slave.
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
);
  logic              halt_req;
  logic              mem_busy;
  logic              branch_taken;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_wen;
  logic              ex_is_load;
  logic              pc_en;
  logic              if_id_en;
  logic              if_id_flush;
  logic              id_ex_en;
  logic              id_ex_flush;
  logic              ex_mem_en;
  logic              mem_wb_en;
  logic [3:0]        stage_valid;
  logic              halted;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output halt_req, mem_busy, branch_taken,
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output ex_rd, ex_wen, ex_is_load,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
    input  ex_mem_en, mem_wb_en, stage_valid, halted, stall_cnt, flush_cnt
  );

  modport slave (
    input  halt_req, mem_busy, branch_taken,
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  ex_rd, ex_wen, ex_is_load,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
    output ex_mem_en, mem_wb_en, stage_valid, halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall/flush sequencer with halt-drain FSM for a 5-stage pipe.
// Define PIPE_PERF_CNT_EN to build the saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
) (
  input logic              clk,
  input logic              rst,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] valid_q, valid_d;   // {v_wb, v_mem, v_ex, v_id}

  logic v_id, v_ex, fetch, frz, br, lu, rs1_hit, rs2_hit;
  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en;
  logic halted;

  assign v_id    = valid_q[0];
  assign v_ex    = valid_q[1];
  assign fetch   = (state_q == ST_RUN);
  assign frz     = bus.mem_busy;
  assign br      = bus.branch_taken & v_ex;
  assign rs1_hit = bus.id_use_rs1 & (bus.id_rs1 == bus.ex_rd);
  assign rs2_hit = bus.id_use_rs2 & (bus.id_rs2 == bus.ex_rd);
  // Register 0 reads as zero, so a load targeting it never creates a dependency.
  assign lu      = v_id & v_ex & bus.ex_is_load & bus.ex_wen &
                   (bus.ex_rd != REG_AW'(0)) & (rs1_hit | rs2_hit);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      valid_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:    if (bus.halt_req) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!bus.halt_req)                     state_d = ST_RUN;
        else if ((valid_q == 4'b0000) && !frz) state_d = ST_HALTED;
      end
      ST_HALTED: if (!bus.halt_req) state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    if (!frz) begin
      valid_d[3] = valid_q[2];
      valid_d[2] = valid_q[1];
      if (br) begin
        valid_d[1] = 1'b0;
        valid_d[0] = 1'b0;
      end else if (lu) begin
        valid_d[1] = 1'b0;
        valid_d[0] = valid_q[0];
      end else begin
        valid_d[1] = valid_q[0];
        valid_d[0] = fetch;
      end
    end
  end

  always_comb begin
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_en    = 1'b0;
    id_ex_flush = 1'b0;
    ex_mem_en   = 1'b0;
    mem_wb_en   = 1'b0;
    if (rst) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (frz) begin
      pc_en = 1'b0;
    end else if (br) begin
      pc_en       = fetch;
      if_id_en    = 1'b1;
      if_id_flush = 1'b1;
      id_ex_en    = 1'b1;
      id_ex_flush = 1'b1;
      ex_mem_en   = 1'b1;
      mem_wb_en   = 1'b1;
    end else if (lu) begin
      id_ex_en    = 1'b1;
      id_ex_flush = 1'b1;
      ex_mem_en   = 1'b1;
      mem_wb_en   = 1'b1;
    end else begin
      // Outside RUN the PC stays put and NOPs are clocked into IF/ID.
      pc_en       = fetch;
      if_id_en    = 1'b1;
      if_id_flush = ~fetch;
      id_ex_en    = 1'b1;
      ex_mem_en   = 1'b1;
      mem_wb_en   = 1'b1;
    end
  end

  assign halted = ~rst & (state_q == ST_HALTED);

  assign bus.pc_en       = pc_en;
  assign bus.if_id_en    = if_id_en;
  assign bus.if_id_flush = if_id_flush;
  assign bus.id_ex_en    = id_ex_en;
  assign bus.id_ex_flush = id_ex_flush;
  assign bus.ex_mem_en   = ex_mem_en;
  assign bus.mem_wb_en   = mem_wb_en;
  assign bus.stage_valid = valid_q;
  assign bus.halted      = halted;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (fetch && !pc_en && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (br && !frz && !(&flush_cnt_q))      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`else
  assign bus.stall_cnt = {CNT_W{1'b0}};
  assign bus.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule
